alu_share_ctrl: RTL and testbench



---
 rtl/alu_share_ctrl.sv | 136 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one ALU between two requesters with private flag registers
module alu_share_ctrl #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 8,
  parameter int FLW     = 5,
  parameter int ALU_LAT = 1
) (
  input  logic             clkout,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req0_val,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [WIDTH-1:0] req1_val,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic [FLW-1:0]   rsp0_flags,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [FLW-1:0]   rsp1_flags,
  output logic             rsp1_err,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_val,
  output logic             alu_cin,
  output logic             alu_fl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [FLW-1:0]   alu_flags
);
  localparam int LW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic gnt, gnt_q, last_grant, acc, legal, upd;
  logic [OPW-1:0] op_in;
  logic [LW-1:0] lat_cnt;
  logic [FLW-1:0] flags0_q, flags1_q;
  assign gnt = (req0_valid && req1_valid) ? !last_grant : req1_valid;
  assign op_in = gnt ? req1_opcode : req0_opcode;
  assign legal = (op_in != '0) && (op_in <= OPW'(53));
  assign upd = alu_opcode <= OPW'(31);
  assign acc = (state == IDLE) && (req0_valid || req1_valid);
  assign rsp0_flags = flags0_q;
  assign rsp1_flags = flags1_q;
  // state register
  always_ff @(posedge clkout or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // next state, grant, ALU strobes and response valids
  always_comb begin
    state_nx = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_fl = 1'b0;
    alu_cin = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: if (acc) begin
        req0_ready = !gnt;
        req1_ready = gnt;
        state_nx = legal ? EXEC : RESP;
      end
      EXEC: begin
        alu_fl = 1'b1;
        alu_cin = gnt_q ? flags1_q[0] : flags0_q[0];
        state_nx = (lat_cnt == '0) ? RESP : EXEC;
      end
      RESP: begin
        rsp0_valid = !gnt_q;
        rsp1_valid = gnt_q;
        state_nx = (gnt_q ? rsp1_ready : rsp0_ready) ? IDLE : RESP;
      end
      default: state_nx = IDLE;
    endcase
  end
  // operand latching into the ALU port registers, result capture and private flags
  always_ff @(posedge clkout or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= 1'b0;
      last_grant <= 1'b1;
      lat_cnt <= '0;
      alu_opcode <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_val <= '0;
      flags0_q <= '0;
      flags1_q <= '0;
      rsp0_result <= '0;
      rsp1_result <= '0;
      rsp0_err <= 1'b0;
      rsp1_err <= 1'b0;
    end else begin
      if (acc) begin
        gnt_q <= gnt;
        last_grant <= gnt;
        lat_cnt <= LW'(ALU_LAT - 1);
        if (legal) begin
          alu_opcode <= op_in;
          alu_a <= gnt ? req1_a : req0_a;
          alu_b <= gnt ? req1_b : req0_b;
          alu_val <= gnt ? req1_val : req0_val;
        end else if (gnt) begin
          rsp1_result <= '0;
          rsp1_err <= 1'b1;
        end else begin
          rsp0_result <= '0;
          rsp0_err <= 1'b1;
        end
      end
      if (state == EXEC) begin
        if (lat_cnt != '0) lat_cnt <= lat_cnt - LW'(1);
        else if (gnt_q) begin
          rsp1_result <= alu_result;
          rsp1_err <= 1'b0;
          if (upd) flags1_q <= alu_flags;
        end else begin
          rsp0_result <= alu_result;
          rsp0_err <= 1'b0;
          if (upd) flags0_q <= alu_flags;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: randomized and directed checks of alu_share_ctrl against an op-level model
module tb_alu_share_ctrl;
  localparam int LAT = 1;
  localparam logic [31:0] A0 = 32'hABCD1234;
  localparam logic [31:0] B0 = 32'hBCDABCAD;
  logic clkout = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, alu_cin, alu_fl;
  logic [7:0] req0_opcode = '0, req1_opcode = '0, alu_opcode;
  logic [31:0] req0_a = '0, req0_b = '0, req0_val = '0, req1_a = '0, req1_b = '0, req1_val = '0;
  logic [31:0] rsp0_result, rsp1_result, alu_a, alu_b, alu_val, alu_result;
  logic [4:0] rsp0_flags, rsp1_flags, alu_flags;
  logic [4:0] mflags [2];
  logic any_out;
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  alu_share_ctrl #(.WIDTH(32), .OPW(8), .FLW(5), .ALU_LAT(LAT)) dut (
    .clkout(clkout), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_val(req0_val),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_val(req1_val),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_val(alu_val),
    .alu_cin(alu_cin), .alu_fl(alu_fl), .alu_result(alu_result), .alu_flags(alu_flags)
  );

  always #5 clkout = ~clkout;
  always @(posedge clkout) cyc <= cyc + 1;

  // ALU behaviour: 1=ADD, 2=ACA (add with carry), 3..31 XOR, 32..53 stack ops (a+val, junk flags)
  function automatic logic [36:0] alu_fn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] v, input logic cin);
    logic [32:0] s;
    if (op == 8'd1) s = {1'b0, a} + {1'b0, b};
    else if (op == 8'd2) s = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    else if (op >= 8'd32) s = {1'b0, a + v};
    else s = {1'b0, a ^ b};
    return (op >= 8'd32) ? {5'h1F, s[31:0]} : {3'b0, s[31:0] == 32'b0, s[32], s[31:0]};
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(alu_opcode, alu_a, alu_b, alu_val, alu_cin);

  assign any_out = |{req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_result, rsp1_result,
                     rsp0_flags, rsp1_flags, rsp0_err, rsp1_err, alu_opcode, alu_a, alu_b, alu_val,
                     alu_cin, alu_fl};

  task automatic drive(input bit p, input logic v, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] val);
    if (p) begin
      req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b; req1_val = val;
    end else begin
      req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b; req0_val = val;
    end
  endtask

  // issue one op on port p alone, collect its response; lat = accept-to-response cycles
  task automatic send(input bit p, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] v, output int lat, output logic [31:0] r, output logic [4:0] f,
                      output logic e, output bit ok, output bit fl_any);
    int n, ta;
    ok = 0; fl_any = 0; lat = 0; r = '0; f = '0; e = 1'b0;
    @(negedge clkout);
    drive(p, 1'b1, op, a, b, v);
    #1;
    n = 0;
    while (!(p ? req1_ready : req0_ready) && n < 50) begin @(negedge clkout); #1; n++; end
    if (n == 50) begin drive(p, 1'b0, '0, '0, '0, '0); return; end
    ta = cyc;
    @(negedge clkout);
    drive(p, 1'b0, '0, '0, '0, '0);
    #1;
    n = 0;
    while (!(p ? rsp1_valid : rsp0_valid) && n < 50) begin
      fl_any |= alu_fl;
      @(negedge clkout); #1; n++;
    end
    if (n == 50) return;
    lat = cyc - ta;
    r = p ? rsp1_result : rsp0_result;
    f = p ? rsp1_flags : rsp0_flags;
    e = p ? rsp1_err : rsp0_err;
    ok = 1;
    if (p) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(negedge clkout);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clkout);
    #1;
    checks++; if (any_out !== 1'b0) begin errors++; $display("FAIL reset_outputs: some output nonzero, required all 0"); end
    @(negedge clkout);
    rst_n = 1'b1;
    #1;
    checks++; if (any_out !== 1'b0) begin errors++; $display("FAIL idle_outputs: some output nonzero, required all 0"); end
    mflags[0] = '0; mflags[1] = '0;
  endtask

  task automatic test_add_timing();
    int lat; logic [31:0] r; logic [4:0] f; logic e; bit ok, fl;
    send(1'b0, 8'd1, A0, B0, 32'h0, lat, r, f, e, ok, fl);
    mflags[0] = 5'h01;
    checks++; if (!ok) begin errors++; $display("FAIL add_timeout: ok=%0d required 1", ok); end
    checks++; if (lat != LAT + 1) begin errors++; $display("FAIL add_latency: got %0d required %0d", lat, LAT + 1); end
    checks++; if (r !== 32'h68A7CEE1) begin errors++; $display("FAIL add_result: got %h required 68a7cee1", r); end
    checks++; if (f !== mflags[0]) begin errors++; $display("FAIL add_flags: got %h required %h", f, mflags[0]); end
    checks++; if (e !== 1'b0 || fl !== 1'b1) begin errors++; $display("FAIL add_err_fl: err=%b fl=%b required 0 1", e, fl); end
  endtask

  task automatic test_carry_private();
    int lat; logic [31:0] r; logic [4:0] f; logic e; bit ok, fl;
    send(1'b0, 8'd2, 32'h0, 32'h0, 32'h0, lat, r, f, e, ok, fl);
    mflags[0] = 5'h00;
    checks++; if (!ok || r !== 32'h1) begin errors++; $display("FAIL aca_port0: ok=%0d got %h required 00000001", ok, r); end
    checks++; if (f !== mflags[0]) begin errors++; $display("FAIL aca_port0_flags: got %h required %h", f, mflags[0]); end
    send(1'b1, 8'd2, 32'h0, 32'h0, 32'h0, lat, r, f, e, ok, fl);
    mflags[1] = 5'h02;
    checks++; if (!ok || r !== 32'h0) begin errors++; $display("FAIL aca_port1: ok=%0d got %h required 00000000", ok, r); end
    checks++; if (f !== mflags[1]) begin errors++; $display("FAIL aca_port1_flags: got %h required %h", f, mflags[1]); end
  endtask

  task automatic test_alternate();
    int ngr, tprev; bit g, exp_g; logic [36:0] e;
    ngr = 0; tprev = 0; exp_g = 1'b0;
    @(negedge clkout);
    drive(1'b0, 1'b1, 8'd1, A0, B0, 32'h0);
    drive(1'b1, 1'b1, 8'd1, 32'h1, 32'h2, 32'h0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int c = 0; c < 40 && ngr < 6; c++) begin
      #1;
      checks++; if (req0_ready && req1_ready) begin errors++; $display("FAIL alt_overlap: both readies high at cycle %0d", cyc); end
      if (req0_ready || req1_ready) begin
        g = req1_ready;
        checks++; if (g != exp_g) begin errors++; $display("FAIL alt_order: grant %0d required %0d", g, exp_g); end
        if (ngr > 0) begin
          checks++; if (cyc - tprev != LAT + 2) begin errors++; $display("FAIL alt_period: got %0d required %0d", cyc - tprev, LAT + 2); end
        end
        e = g ? alu_fn(8'd1, 32'h1, 32'h2, 32'h0, 1'b0) : alu_fn(8'd1, A0, B0, 32'h0, 1'b0);
        mflags[g] = e[36:32];
        tprev = cyc; ngr++; exp_g = !g;
      end
      if (rsp0_valid) begin
        checks++; if (rsp0_result !== 32'h68A7CEE1) begin errors++; $display("FAIL alt_rsp0: got %h required 68a7cee1", rsp0_result); end
      end
      if (rsp1_valid) begin
        checks++; if (rsp1_result !== 32'h3) begin errors++; $display("FAIL alt_rsp1: got %h required 00000003", rsp1_result); end
      end
      @(negedge clkout);
    end
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0, '0);
    repeat (LAT + 3) @(negedge clkout);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    checks++; if (ngr != 6) begin errors++; $display("FAIL alt_count: got %0d grants required 6", ngr); end
  endtask

  task automatic test_backpressure();
    logic [36:0] e, e1; logic [31:0] held; int n;
    @(negedge clkout);
    drive(1'b0, 1'b1, 8'd1, A0, B0, 32'h0);
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_grant0: ready=%b required 1", req0_ready); end
    e = alu_fn(8'd1, A0, B0, 32'h0, mflags[0][0]);
    mflags[0] = e[36:32];
    @(negedge clkout);
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    drive(1'b1, 1'b1, 8'd3, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0);
    #1;
    n = 0;
    while (!rsp0_valid && n < 20) begin @(negedge clkout); #1; n++; end
    held = rsp0_result;
    checks++; if (rsp0_valid !== 1'b1 || held !== e[31:0]) begin errors++; $display("FAIL bp_rsp0: valid=%b got %h required %h", rsp0_valid, held, e[31:0]); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clkout); #1;
      checks++;
      if (rsp0_valid !== 1'b1 || rsp0_result !== held || req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold: valid=%b result=%h req1_ready=%b required 1 %h 0", rsp0_valid, rsp0_result, req1_ready, held);
      end
    end
    rsp0_ready = 1'b1;
    @(negedge clkout);
    rsp0_ready = 1'b0;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_next_grant: req1_ready=%b required 1", req1_ready); end
    e1 = alu_fn(8'd3, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0, mflags[1][0]);
    mflags[1] = e1[36:32];
    @(negedge clkout);
    drive(1'b1, 1'b0, '0, '0, '0, '0);
    #1;
    n = 0;
    while (!rsp1_valid && n < 20) begin @(negedge clkout); #1; n++; end
    checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== e1[31:0] || rsp1_flags !== mflags[1]) begin
      errors++; $display("FAIL bp_rsp1: valid=%b got %h/%h required %h/%h", rsp1_valid, rsp1_result, rsp1_flags, e1[31:0], mflags[1]);
    end
    rsp1_ready = 1'b1;
    @(negedge clkout);
    rsp1_ready = 1'b0;
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] r; logic [4:0] f; logic e; bit ok, fl;
    send(1'b0, 8'd0, 32'h1234, 32'h5678, 32'h0, lat, r, f, e, ok, fl);
    checks++; if (!ok || lat != 1) begin errors++; $display("FAIL ill0_latency: ok=%0d got %0d required 1", ok, lat); end
    checks++; if (r !== 32'h0 || e !== 1'b1 || f !== mflags[0]) begin errors++; $display("FAIL ill0_rsp: result=%h err=%b flags=%h required 0 1 %h", r, e, f, mflags[0]); end
    checks++; if (fl !== 1'b0) begin errors++; $display("FAIL ill0_alu_fl: got %b required 0", fl); end
    send(1'b1, 8'd60, 32'h1234, 32'h5678, 32'h0, lat, r, f, e, ok, fl);
    checks++; if (!ok || lat != 1) begin errors++; $display("FAIL ill60_latency: ok=%0d got %0d required 1", ok, lat); end
    checks++; if (r !== 32'h0 || e !== 1'b1 || f !== mflags[1]) begin errors++; $display("FAIL ill60_rsp: result=%h err=%b flags=%h required 0 1 %h", r, e, f, mflags[1]); end
    checks++; if (fl !== 1'b0) begin errors++; $display("FAIL ill60_alu_fl: got %b required 0", fl); end
  endtask

  task automatic test_psh_and_reset();
    int lat; logic [31:0] r; logic [4:0] f; logic e; bit ok, fl;
    send(1'b0, 8'd1, A0, B0, 32'h0, lat, r, f, e, ok, fl);
    mflags[0] = 5'h01;
    send(1'b0, 8'd40, 32'h100, 32'h0, 32'h4, lat, r, f, e, ok, fl);
    checks++; if (!ok || r !== 32'h104) begin errors++; $display("FAIL psh_result: ok=%0d got %h required 00000104", ok, r); end
    checks++; if (f !== mflags[0] || e !== 1'b0) begin errors++; $display("FAIL psh_flags: flags=%h err=%b required %h 0", f, e, mflags[0]); end
    @(negedge clkout);
    drive(1'b0, 1'b1, 8'd1, A0, B0, 32'h0);
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rst_grant: ready=%b required 1", req0_ready); end
    @(negedge clkout);
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    #1;
    checks++; if (alu_fl !== 1'b1) begin errors++; $display("FAIL rst_exec: alu_fl=%b required 1", alu_fl); end
    rst_n = 1'b0;
    #1;
    checks++; if (any_out !== 1'b0) begin errors++; $display("FAIL rst_midop: some output nonzero, required all 0"); end
    @(negedge clkout);
    rst_n = 1'b1;
    mflags[0] = '0; mflags[1] = '0;
    repeat (3) @(negedge clkout);
    #1;
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL rst_no_rsp: rsp0_valid=%b required 0", rsp0_valid); end
    send(1'b0, 8'd2, 32'h0, 32'h0, 32'h0, lat, r, f, e, ok, fl);
    mflags[0] = 5'h02;
    checks++; if (!ok || r !== 32'h0 || f !== mflags[0]) begin errors++; $display("FAIL rst_carry_cleared: ok=%0d got %h/%h required 0/%h", ok, r, f, mflags[0]); end
  endtask

  task automatic test_random();
    int lat, k; logic [31:0] r, a, b, v, er; logic [4:0] f; logic e; bit ok, fl, p, lg;
    logic [7:0] op; logic [36:0] x;
    for (int i = 0; i < 40; i++) begin
      p = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 9);
      op = (k == 0) ? 8'd0 : (k == 1) ? 8'($urandom_range(54, 255)) : (k < 4) ? 8'd1 :
           (k < 6) ? 8'd2 : (k < 8) ? 8'($urandom_range(3, 31)) : 8'($urandom_range(32, 53));
      a = $urandom; b = $urandom; v = $urandom;
      if (k > 3 && k < 6 && $urandom_range(0, 1) == 1) begin a = 32'hFFFFFFFF; b = 32'h0; end
      lg = (op != 8'd0) && (op <= 8'd53);
      x = alu_fn(op, a, b, v, mflags[p][0]);
      er = lg ? x[31:0] : 32'h0;
      if (lg && op <= 8'd31) mflags[p] = x[36:32];
      send(p, op, a, b, v, lat, r, f, e, ok, fl);
      checks++; if (!ok || r !== er) begin errors++; $display("FAIL rand_result[%0d] p%0d op%0d: ok=%0d got %h required %h", i, p, op, ok, r, er); end
      checks++; if (f !== mflags[p]) begin errors++; $display("FAIL rand_flags[%0d] p%0d op%0d: got %h required %h", i, p, op, f, mflags[p]); end
      checks++; if (e !== !lg) begin errors++; $display("FAIL rand_err[%0d] op%0d: got %b required %b", i, op, e, !lg); end
      checks++; if (lat != (lg ? LAT + 1 : 1)) begin errors++; $display("FAIL rand_latency[%0d] op%0d: got %0d required %0d", i, op, lat, lg ? LAT + 1 : 1); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_timing();
    test_carry_private();
    test_alternate();
    test_backpressure();
    test_illegal();
    test_psh_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
